// File: rtl/gpu_l2_arbiter.sv
// Round-robin arbiter for NUM_REQ shader clusters sharing one L2 port; one transaction in flight at a time.
// Grant is combinational in IDLE, the response one cycle after L2 completes; requesters stall (ready=0) while a command is busy.
module gpu_l2_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 40,
    parameter int DATA_W      = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        enable_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        l2_read_o,
    output logic                        l2_write_o,
    output logic [ADDR_W-1:0]           l2_addr_o,
    output logic [DATA_W-1:0]           l2_wdata_o,
    input  logic                        l2_ready_i,
    input  logic [DATA_W-1:0]           l2_rdata_i,
    output logic                        busy_o,
    output logic                        fault_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                fault_q, fault_d;

    logic                pick_vld;
    logic [PTR_W-1:0]    pick_idx;

    // First valid requester at or after rr_ptr, wrapping, so an idle requester costs no cycle.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && req_valid_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        fault_d     = 1'b0;
        req_ready_o = '0;
        rsp_valid_o = '0;
        l2_read_o   = 1'b0;
        l2_write_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable_i && rst_n_i && pick_vld) begin
                    req_ready_o[pick_idx] = 1'b1;
                    gnt_d    = pick_idx;
                    wr_d     = req_write_i[pick_idx];
                    addr_d   = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d  = req_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
                    rr_ptr_d = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                l2_read_o  = !wr_q;
                l2_write_o = wr_q;
                // Completion takes priority over a timeout landing in the same cycle.
                if (l2_ready_i) begin
                    rdata_d = wr_q ? '0 : l2_rdata_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid_o[gnt_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            fault_q  <= fault_d;
        end
    end

    assign l2_addr_o   = addr_q;
    assign l2_wdata_o  = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign fault_o     = fault_q;
    assign busy_o      = (state_q != IDLE);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            assert ($onehot0(req_ready_o));
            assert ($onehot0(rsp_valid_o));
            assert (!(l2_read_o && l2_write_o));
        end
    end
`endif

endmodule

// File: doc/gpu_l2_arbiter.md
GPU_L2_ARBITER -- requirements
Module: gpu_l2_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of shader-cluster requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 40, meaning the L2 address width.
REQ-003 SHALL have parameter DATA_W, default 256, meaning the L2 data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum BUSY cycles before a fault.
REQ-005 SHALL have port clk_i, input, 1, the clock; rst_n_i, input, 1, the reset, asynchronous and active-low.
REQ-006 SHALL have port enable_i, input, 1, meaning new grants are permitted.
REQ-007 SHALL have port req_valid_i, input, NUM_REQ, meaning per-requester request valid.
REQ-008 SHALL have port req_write_i, input, NUM_REQ, meaning 1=write, 0=read.
REQ-009 SHALL have port req_addr_i, input, NUM_REQ x ADDR_W, meaning per-requester address.
REQ-010 SHALL have port req_wdata_i, input, NUM_REQ x DATA_W, meaning per-requester write data.
REQ-011 SHALL have port req_ready_o, output, NUM_REQ, meaning one-hot accept.
REQ-012 SHALL have port rsp_valid_o, output, NUM_REQ, meaning one-hot response pulse.
REQ-013 SHALL have port rsp_rdata_o, output, DATA_W, meaning response read data shared by all requesters.
REQ-014 SHALL have port rsp_err_o, output, 1, meaning the response ended by timeout.
REQ-015 SHALL have ports l2_read_o and l2_write_o, output, 1 each, meaning L2 command strobes.
REQ-016 SHALL have ports l2_addr_o (ADDR_W) and l2_wdata_o (DATA_W), output, meaning L2 command payload.
REQ-017 SHALL have ports l2_ready_i (1) and l2_rdata_i (DATA_W), input, meaning L2 completion and read data.
REQ-018 SHALL have ports busy_o (1) and fault_o (1), output, meaning a transaction is in flight, and a one-cycle timeout pulse.

Function
REQ-019 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-020 In IDLE with enable_i=1 and any req_valid_i set, SHALL combinationally assert req_ready_o for exactly one requester, chosen round-robin from the pointer rr_ptr.
- Handshake: valid&&ready means accepted.
- Transition to BUSY.
REQ-021 On acceptance SHALL register the grant index, write flag, address and wdata, and set rr_ptr=(grant+1) mod NUM_REQ.
REQ-022 In BUSY SHALL hold the command stable until l2_ready_i=1:
- l2_read_o=!wr, l2_write_o=wr.
- l2_addr_o and l2_wdata_o driven from the registered values.
REQ-023 When l2_ready_i=1 in BUSY, SHALL capture l2_rdata_i (or 0 for a write) and go to RESP; l2 strobes deassert in the following cycle.
REQ-024 In RESP SHALL drive, for exactly one cycle, then return to IDLE:
- rsp_valid_o[grant]=1.
- rsp_rdata_o=captured data.
- rsp_err_o=the timeout flag.
REQ-025 Minimum accept-to-next-accept interval SHALL be 3 cycles (IDLE, BUSY, RESP) when l2_ready_i is asserted in the first BUSY cycle.
REQ-026 SHALL count BUSY cycles with a counter cleared on BUSY entry; on reaching TIMEOUT_CYC with no l2_ready_i:
- Drop the strobes.
- Pulse fault_o for 1 cycle.
- Set the timeout flag and data=0, and enter RESP.
REQ-027 If l2_ready_i and the timeout occur in the same cycle, ready SHALL win: normal response, no fault.
REQ-028 SHALL ignore l2_ready_i outside BUSY.
REQ-029 SHALL assert req_ready_o only in IDLE, and never while enable_i=0.
REQ-030 Deasserting enable_i during BUSY or RESP SHALL NOT abort the in-flight transaction.
REQ-031 Outside RESP, rsp_valid_o SHALL be 0, rsp_rdata_o and rsp_err_o SHALL hold their last values, and busy_o SHALL be 1 in BUSY and RESP.
REQ-032 The pointer SHALL wrap NUM_REQ-1 to 0; a requester not ready SHALL be skipped with no idle cycle.

Reset
REQ-033 Asynchronous reset SHALL force:
- state=IDLE, rr_ptr=0, counter=0.
- All strobes, req_ready_o, rsp_valid_o, rsp_err_o, fault_o and busy_o=0.
- rsp_rdata_o, l2_addr_o and l2_wdata_o=0.
REQ-034 Reset mid-transaction SHALL discard the transaction with no response; the first post-reset grant goes to the lowest-index valid requester.

Verification
REQ-035 Verification SHALL cover a single read:
- Stimulus: req0 read at 0x1000; L2 ready 2 cycles later with data 0xA5...
- Response: rsp_valid_o=2'b01 for 1 cycle, rsp_rdata_o=0xA5..., rsp_err_o=0.
REQ-036 Verification SHALL cover fairness:
- Stimulus: both requesters valid continuously; L2 ready immediately.
- Response: grants alternate 0,1,0,1 and each accept is 3 cycles apart.
REQ-037 Verification SHALL cover a write:
- Stimulus: req1 write at addr 0x20, wdata 0x55.
- Response: l2_write_o=1 with addr 0x20 and wdata 0x55 until ready; rsp_rdata_o=0.
REQ-038 Verification SHALL cover a timeout:
- Stimulus: TIMEOUT_CYC=8, no l2_ready_i.
- Response: after 8 BUSY cycles fault_o pulses, then rsp_valid_o with rsp_err_o=1 and data=0.
REQ-039 Verification SHALL cover enable gating:
- Stimulus: enable_i=0 with req0 valid.
- Response: no req_ready_o; on enable_i=1, grant in the same cycle.
REQ-040 Verification SHALL cover reset mid-operation:
- Stimulus: reset asserted in BUSY.
- Response: strobes 0 immediately; no rsp_valid_o; post-reset grant goes to requester 0.
